// File: rtl/tank_projectile.sv
// tank_projectile: per-player shell unit.
// Tracks the tank's facing direction and fires one shell on a fresh fire press.
// The shell steps one tile every STEP_DIV frames. It reports a wall or map-edge
// hit and an opponent hit, then holds off re-firing for COOLDOWN frames.
// Ports:
//   frame_clk           frame clock (sole clock)
//   Reset               synchronous active-high reset
//   player              1: WASD + space fire, 0: arrows + enter fire
//   keycode[7:0]        current USB keycode
//   TankX/TankY         own tank tile
//   OppX/OppY           opponent tank tile
//   map_wall            wall bitmap, bit Y*MAP_W+X
//   bullet_active       shell in flight
//   BulletX/BulletY     shell tile, 0 when inactive
//   opp_hit, wall_hit   one-frame hit pulses
//   fire_ready          idle and fire key armed
module tank_projectile #(
   parameter int unsigned MAP_W     = 20,
   parameter int unsigned MAP_H     = 15,
   parameter int unsigned STEP_DIV  = 2,
   parameter int unsigned MAX_RANGE = 12,
   parameter int unsigned COOLDOWN  = 30
) (
   input  logic                   frame_clk,
   input  logic                   Reset,
   input  logic                   player,
   input  logic [7:0]             keycode,
   input  logic [4:0]             TankX,
   input  logic [3:0]             TankY,
   input  logic [4:0]             OppX,
   input  logic [3:0]             OppY,
   input  logic [MAP_W*MAP_H-1:0] map_wall,
   output logic                   bullet_active,
   output logic [4:0]             BulletX,
   output logic [3:0]             BulletY,
   output logic                   opp_hit,
   output logic                   wall_hit,
   output logic                   fire_ready
);

   localparam int unsigned CELLS  = MAP_W * MAP_H;
   localparam int unsigned IDX_W  = $clog2(CELLS);
   localparam int unsigned STEP_W = $clog2(STEP_DIV + 1);
   localparam int unsigned RNG_W  = $clog2(MAX_RANGE + 1);
   localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);

   typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   state_t            state, state_n;
   dir_t              dir, dir_n, bdir, bdir_n;
   logic              armed, armed_n;
   logic [STEP_W-1:0] step_cnt, step_cnt_n;
   logic [RNG_W-1:0]  range_cnt, range_cnt_n;
   logic [COOL_W-1:0] cool_cnt, cool_cnt_n;
   logic              active_n, opp_hit_n, wall_hit_n, fire_ready_n;
   logic [4:0]        bx_n;
   logic [3:0]        by_n;

   logic              key_dir_vld;
   dir_t              key_dir;
   logic [7:0]        fire_key;
   logic              fire_press;

   logic [4:0]        src_x;
   logic [3:0]        src_y;
   dir_t              src_dir;
   logic signed [5:0] dx, dy, nx, ny;
   logic [IDX_W-1:0]  widx;
   logic              nxt_oob, nxt_wall, nxt_opp;

   // Keycode decode: this player's fire key and direction keys
   always_comb begin
      key_dir_vld = 1'b0;
      key_dir     = DIR_UP;
      fire_key    = player ? 8'h2C : 8'h28;
      if (player) begin
         case (keycode)
            8'h04:   begin key_dir_vld = 1'b1; key_dir = DIR_LEFT;  end
            8'h07:   begin key_dir_vld = 1'b1; key_dir = DIR_RIGHT; end
            8'h16:   begin key_dir_vld = 1'b1; key_dir = DIR_DOWN;  end
            8'h1A:   begin key_dir_vld = 1'b1; key_dir = DIR_UP;    end
            default: ;
         endcase
      end else begin
         case (keycode)
            8'h50:   begin key_dir_vld = 1'b1; key_dir = DIR_LEFT;  end
            8'h4F:   begin key_dir_vld = 1'b1; key_dir = DIR_RIGHT; end
            8'h51:   begin key_dir_vld = 1'b1; key_dir = DIR_DOWN;  end
            8'h52:   begin key_dir_vld = 1'b1; key_dir = DIR_UP;    end
            default: ;
         endcase
      end
      fire_press = (keycode == fire_key);
   end

   // Next-tile lookup: from the tank when idle, from the shell otherwise
   always_comb begin
      src_x   = (state == IDLE) ? TankX : BulletX;
      src_y   = (state == IDLE) ? TankY : BulletY;
      src_dir = (state == IDLE) ? dir : bdir;
      dx = 6'sd0;
      dy = 6'sd0;
      case (src_dir)
         DIR_UP:    dy = -6'sd1;
         DIR_DOWN:  dy =  6'sd1;
         DIR_LEFT:  dx = -6'sd1;
         DIR_RIGHT: dx =  6'sd1;
         default:   ;
      endcase
      nx = $signed({1'b0, src_x}) + dx;
      ny = $signed({2'b00, src_y}) + dy;
      // Negative coordinates show up as the sign bit
      nxt_oob  = nx[5] || ny[5] || (32'(nx[4:0]) >= MAP_W) || (32'(ny[4:0]) >= MAP_H);
      widx     = IDX_W'(32'(ny[4:0]) * MAP_W + 32'(nx[4:0]));
      nxt_wall = !nxt_oob && map_wall[widx];
      nxt_opp  = (nx[4:0] == OppX) && (ny[3:0] == OppY);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n      = state;
      dir_n        = key_dir_vld ? key_dir : dir;
      bdir_n       = bdir;
      armed_n      = fire_press ? armed : 1'b1;
      step_cnt_n   = step_cnt;
      range_cnt_n  = range_cnt;
      cool_cnt_n   = cool_cnt;
      active_n     = bullet_active;
      bx_n         = BulletX;
      by_n         = BulletY;
      opp_hit_n    = 1'b0;
      wall_hit_n   = 1'b0;
      fire_ready_n = 1'b0;

      case (state)
         IDLE: begin
            if (fire_press && armed) begin
               armed_n = 1'b0;
               bdir_n  = dir;
               if (nxt_oob || nxt_wall) begin
                  wall_hit_n = 1'b1;
                  state_n    = COOL;
                  cool_cnt_n = '0;
               end else if (nxt_opp) begin
                  opp_hit_n  = 1'b1;
                  state_n    = COOL;
                  cool_cnt_n = '0;
               end else begin
                  bx_n        = nx[4:0];
                  by_n        = ny[3:0];
                  active_n    = 1'b1;
                  range_cnt_n = RNG_W'(1);
                  step_cnt_n  = '0;
                  state_n     = FLY;
               end
            end
         end
         FLY: begin
            if ((BulletX == OppX) && (BulletY == OppY)) begin
               // Opponent drove onto the shell between steps
               opp_hit_n  = 1'b1;
               active_n   = 1'b0;
               bx_n       = '0;
               by_n       = '0;
               state_n    = COOL;
               cool_cnt_n = '0;
            end else if (step_cnt < STEP_W'(STEP_DIV - 1)) begin
               step_cnt_n = step_cnt + STEP_W'(1);
            end else begin
               step_cnt_n = '0;
               if (nxt_oob || nxt_wall || (range_cnt == RNG_W'(MAX_RANGE)) || nxt_opp) begin
                  // Wall beats range expiry, which beats an opponent hit
                  wall_hit_n = nxt_oob || nxt_wall;
                  opp_hit_n  = !(nxt_oob || nxt_wall) && (range_cnt != RNG_W'(MAX_RANGE)) && nxt_opp;
                  active_n   = 1'b0;
                  bx_n       = '0;
                  by_n       = '0;
                  state_n    = COOL;
                  cool_cnt_n = '0;
               end else begin
                  bx_n        = nx[4:0];
                  by_n        = ny[3:0];
                  range_cnt_n = range_cnt + RNG_W'(1);
               end
            end
         end
         COOL: begin
            if (cool_cnt == COOL_W'(COOLDOWN - 1)) begin
               cool_cnt_n = '0;
               state_n    = IDLE;
            end else begin
               cool_cnt_n = cool_cnt + COOL_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      fire_ready_n = (state_n == IDLE) && armed_n;
   end

   // State and output registers
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state         <= IDLE;
         dir           <= player ? DIR_UP : DIR_DOWN;
         bdir          <= DIR_UP;
         armed         <= 1'b1;
         step_cnt      <= '0;
         range_cnt     <= '0;
         cool_cnt      <= '0;
         bullet_active <= 1'b0;
         BulletX       <= '0;
         BulletY       <= '0;
         opp_hit       <= 1'b0;
         wall_hit      <= 1'b0;
         fire_ready    <= 1'b1;
      end else begin
         state         <= state_n;
         dir           <= dir_n;
         bdir          <= bdir_n;
         armed         <= armed_n;
         step_cnt      <= step_cnt_n;
         range_cnt     <= range_cnt_n;
         cool_cnt      <= cool_cnt_n;
         bullet_active <= active_n;
         BulletX       <= bx_n;
         BulletY       <= by_n;
         opp_hit       <= opp_hit_n;
         wall_hit      <= wall_hit_n;
         fire_ready    <= fire_ready_n;
      end
   end

endmodule

// File: tb/tb_tank_projectile.sv
// Bench for tank_projectile: directed scenarios plus random play.
// Every frame is compared with a frame-level reference model.
module tb_tank_projectile;

   localparam int MAP_W     = 20;
   localparam int MAP_H     = 15;
   localparam int STEP_DIV  = 2;
   localparam int MAX_RANGE = 12;
   localparam int COOLDOWN  = 30;

   logic         frame_clk = 1'b0;
   logic         Reset;
   logic         player;
   logic [7:0]   keycode;
   logic [4:0]   TankX, OppX;
   logic [3:0]   TankY, OppY;
   logic [299:0] map_wall;
   logic         bullet_active, opp_hit, wall_hit, fire_ready;
   logic [4:0]   BulletX;
   logic [3:0]   BulletY;

   tank_projectile #(
      .MAP_W(MAP_W), .MAP_H(MAP_H), .STEP_DIV(STEP_DIV),
      .MAX_RANGE(MAX_RANGE), .COOLDOWN(COOLDOWN)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .player(player), .keycode(keycode),
      .TankX(TankX), .TankY(TankY), .OppX(OppX), .OppY(OppY), .map_wall(map_wall),
      .bullet_active(bullet_active), .BulletX(BulletX), .BulletY(BulletY),
      .opp_hit(opp_hit), .wall_hit(wall_hit), .fire_ready(fire_ready)
   );

   always #5 frame_clk = ~frame_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Key tables: left, right, down, up
   logic [7:0] keys_p1 [4] = '{8'h04, 8'h07, 8'h16, 8'h1A};
   logic [7:0] keys_p0 [4] = '{8'h50, 8'h4F, 8'h51, 8'h52};
   int         key_dx  [4] = '{-1, 1, 0, 0};
   int         key_dy  [4] = '{0, 0, 1, -1};

   // Reference model state
   int m_mode;            // 0 idle, 1 flying, 2 cooling
   int m_dx, m_dy;        // facing
   int b_dx, b_dy;        // shell heading, frozen at launch
   int m_bx, m_by, m_travel, m_age, m_cool_left;
   bit m_act, m_armed, m_opp, m_wall;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit blocked(input int x, input int y);
      if (x < 0 || x >= MAP_W || y < 0 || y >= MAP_H) return 1'b1;
      return map_wall[y*MAP_W + x];
   endfunction

   task automatic to_cool();
      m_mode      = 2;
      m_cool_left = COOLDOWN;
      m_act       = 1'b0;
      m_bx        = 0;
      m_by        = 0;
   endtask

   // Advance the model by one frame using the inputs present at the edge
   task automatic model_step();
      int  fk, nx, ny;
      bit  launched;
      m_opp = 1'b0;
      m_wall = 1'b0;
      if (Reset) begin
         m_mode = 0; m_act = 1'b0; m_bx = 0; m_by = 0; m_armed = 1'b1;
         m_dx = 0; m_dy = player ? -1 : 1;
         m_travel = 0; m_age = 0; m_cool_left = 0;
         return;
      end
      fk = player ? 'h2C : 'h28;
      launched = 1'b0;
      case (m_mode)
         0: if (int'(keycode) == fk && m_armed) begin
               launched = 1'b1;
               b_dx = m_dx; b_dy = m_dy;
               nx = int'(TankX) + b_dx;
               ny = int'(TankY) + b_dy;
               if (blocked(nx, ny)) begin m_wall = 1'b1; to_cool(); end
               else if (nx == int'(OppX) && ny == int'(OppY)) begin m_opp = 1'b1; to_cool(); end
               else begin
                  m_mode = 1; m_act = 1'b1; m_bx = nx; m_by = ny; m_travel = 1; m_age = 0;
               end
            end
         1: begin
               m_age++;
               if (m_bx == int'(OppX) && m_by == int'(OppY)) begin m_opp = 1'b1; to_cool(); end
               else if (m_age % STEP_DIV == 0) begin
                  nx = m_bx + b_dx;
                  ny = m_by + b_dy;
                  if (blocked(nx, ny)) begin m_wall = 1'b1; to_cool(); end
                  else if (m_travel == MAX_RANGE) to_cool();
                  else if (nx == int'(OppX) && ny == int'(OppY)) begin m_opp = 1'b1; to_cool(); end
                  else begin m_bx = nx; m_by = ny; m_travel++; end
               end
            end
         default: begin
               m_cool_left--;
               if (m_cool_left == 0) m_mode = 0;
            end
      endcase
      if (int'(keycode) != fk) m_armed = 1'b1;
      if (launched) m_armed = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (keycode == (player ? keys_p1[i] : keys_p0[i])) begin
            m_dx = key_dx[i];
            m_dy = key_dy[i];
         end
      end
   endtask

   // One frame: edge, model update, then compare all outputs
   task automatic tick();
      @(posedge frame_clk);
      model_step();
      #1;
      check("active",     int'(bullet_active), int'(m_act));
      check("bullet_x",   int'(BulletX),       m_bx);
      check("bullet_y",   int'(BulletY),       m_by);
      check("opp_hit",    int'(opp_hit),       int'(m_opp));
      check("wall_hit",   int'(wall_hit),      int'(m_wall));
      check("fire_ready", int'(fire_ready),    int'(m_mode == 0 && m_armed));
   endtask

   task automatic do_reset(input logic p);
      Reset = 1'b1; player = p; keycode = 8'h00;
      tick();
      Reset = 1'b0;
   endtask

   initial begin
      int n, prev_y, cnt, maxx, pulses;

      // T1: launch UP and first step
      TankX = 5'd1; TankY = 4'd13; OppX = 5'd10; OppY = 4'd0; map_wall = '0;
      do_reset(1'b1);
      check("rst_active", int'(bullet_active), 0);
      check("rst_ready",  int'(fire_ready), 1);
      check("rst_pulses", int'(opp_hit) + int'(wall_hit), 0);
      keycode = 8'h1A; tick();
      keycode = 8'h2C; tick();
      check("t1_launch_x", int'(BulletX), 1);
      check("t1_launch_y", int'(BulletY), 12);
      check("t1_launch_active", int'(bullet_active), 1);
      keycode = 8'h00; tick();
      check("t1_hold_y", int'(BulletY), 12);
      tick();
      check("t1_step_y", int'(BulletY), 11);

      // T2: wall at (1,10), then cooldown
      map_wall = '0; map_wall[10*MAP_W + 1] = 1'b1;
      do_reset(1'b1);
      keycode = 8'h2C; tick();
      keycode = 8'h00;
      n = 0; prev_y = -1;
      for (int i = 0; i < 12; i++) begin
         prev_y = int'(BulletY);
         tick(); n++;
         if (wall_hit) break;
      end
      check("t2_hit_latency", n, 4);
      check("t2_y_before_hit", prev_y, 11);
      check("t2_inactive", int'(bullet_active), 0);
      repeat (COOLDOWN - 1) tick();
      check("t2_cool_not_ready", int'(fire_ready), 0);
      tick();
      check("t2_ready", int'(fire_ready), 1);

      // T3: player 0 facing DOWN hits opponent
      map_wall = '0; TankX = 5'd18; TankY = 4'd1; OppX = 5'd18; OppY = 4'd5;
      do_reset(1'b0);
      keycode = 8'h28; tick();
      check("t3_launch_y", int'(BulletY), 2);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick(); n++;
         if (opp_hit) break;
      end
      check("t3_latency", n, 6);
      check("t3_deact_same_edge", int'(bullet_active), 0);
      tick();
      check("t3_pulse_width", int'(opp_hit), 0);

      // T4: fire held through cooldown does not relaunch
      cnt = 0;
      repeat (40) begin tick(); cnt += int'(bullet_active); end
      check("t4_no_relaunch", cnt, 0);
      keycode = 8'h00; tick();
      keycode = 8'h28; OppX = 5'd5; tick();
      check("t4_relaunch", int'(bullet_active), 1);

      // T5: range expiry along an open row, then edge launch
      map_wall = '0; TankX = 5'd0; TankY = 4'd7; OppX = 5'd5; OppY = 4'd0;
      do_reset(1'b1);
      keycode = 8'h07; tick();
      keycode = 8'h2C; tick();
      keycode = 8'h00;
      maxx = int'(BulletX); pulses = 0; cnt = 0;
      repeat (30) begin
         tick();
         if (bullet_active) begin cnt++; if (int'(BulletX) > maxx) maxx = int'(BulletX); end
         pulses += int'(opp_hit) + int'(wall_hit);
      end
      check("t5_max_x", maxx, 12);
      check("t5_no_pulse", pulses, 0);
      check("t5_flight_frames", cnt, 23);
      repeat (COOLDOWN) tick();
      TankX = 5'd19;
      keycode = 8'h2C; tick();
      check("t5_edge_wall", int'(wall_hit), 1);
      check("t5_edge_inactive", int'(bullet_active), 0);
      keycode = 8'h00;

      // T6: reset mid-flight
      TankX = 5'd5; TankY = 4'd10; OppX = 5'd0; OppY = 4'd0;
      do_reset(1'b1);
      keycode = 8'h04; tick();
      keycode = 8'h2C; tick();
      keycode = 8'h00; repeat (3) tick();
      check("t6_flying", int'(bullet_active), 1);
      Reset = 1'b1; keycode = 8'h07; tick();
      check("t6_active", int'(bullet_active), 0);
      check("t6_xy", int'(BulletX) + int'(BulletY), 0);
      check("t6_pulses", int'(opp_hit) + int'(wall_hit), 0);
      check("t6_ready", int'(fire_ready), 1);
      Reset = 1'b0; keycode = 8'h2C; tick();
      check("t6_dir_reset_x", int'(BulletX), 5);
      check("t6_dir_reset_y", int'(BulletY), 9);

      // Random play against the model
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            for (int i = 0; i < 300; i++) map_wall[i] = ($urandom_range(0, 9) == 0);
            player = 1'($urandom_range(0, 1));
            Reset = 1'b1;
         end else begin
            Reset = ($urandom_range(0, 199) == 0);
         end
         if ($urandom_range(0, 9) == 0) begin
            TankX = 5'($urandom_range(0, MAP_W - 1));
            TankY = 4'($urandom_range(0, MAP_H - 1));
         end
         if ($urandom_range(0, 6) == 0) begin
            OppX = 5'($urandom_range(0, MAP_W - 1));
            OppY = 4'($urandom_range(0, MAP_H - 1));
         end
         if ($urandom_range(0, 2) == 0) begin
            n = int'($urandom_range(0, 9));
            if (n < 3)      keycode = player ? 8'h2C : 8'h28;
            else if (n < 6) keycode = 8'h00;
            else if (n < 9) begin
               n = int'($urandom_range(0, 3));
               keycode = player ? keys_p1[n] : keys_p0[n];
            end else        keycode = 8'($urandom);
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
